rect_copy_controller: RTL and testbench
=======================================

// Module: rect_copy_controller
// PURPOSE
//  Transmit side of the GPU rect-load stream. On a start request, fetches RECT_COUNT rect records
//  (x, y, width, height, color) from a synchronous-read RAM and feeds them to the gpu with its
//  6-cycle-per-rect cadence (1 gap slot + 5 data slots). Also issues gpu_reset + copy_start so the
//  gpu can be reloaded every frame. Sits between the CPU-side rect RAM and the gpu block.
// PARAMETERS
//  RECT_COUNT   64  rects per frame; gpu expects exactly 64
//  ADDR_WIDTH   16  rect RAM address width
//  DATA_WIDTH   16  word width (coords and color)
// PORTS
//  pixel_clk    in   1           clock
//  reset        in   1           synchronous, active-high
//  start        in   1           request a copy; sampled only in IDLE
//  base_addr    in   ADDR_WIDTH  RAM address of rect 0 word 0; latched at accepted start
//  mem_rd_en    out  1           RAM read strobe
//  mem_addr     out  ADDR_WIDTH  RAM read address
//  mem_dout     in   DATA_WIDTH  RAM read data, valid 1 cycle after mem_rd_en
//  gpu_reset    out  1           1-cycle pulse returning gpu to WAIT_FOR_COPY
//  copy_start   out  1           1-cycle pulse, gpu copy trigger
//  gpu_data     out  DATA_WIDTH  registered word to gpu mem_din
//  busy         out  1           copy in progress
//  done         out  1           1-cycle pulse after last word
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters 0. Reset mid-copy aborts immediately, no done.
//  - RAM layout: word k of rect r at base_addr + 5*r + k; k: 0 x, 1 y, 2 width, 3 height, 4 color.
//    Address arithmetic mod 2^ADDR_WIDTH (wraps silently).
//  - States: IDLE -> GPU_RST -> START -> STREAM -> DONE -> IDLE.
//  - Timing, S = cycle start is sampled high in IDLE:
//    S+1 GPU_RST: gpu_reset=1, busy=1.  S+2 START: copy_start=1.
//    STREAM: slot counter 0..5 (0 = gap), rect counter 0..RECT_COUNT-1.
//    Word (r,k) read: mem_rd_en=1, mem_addr valid in cycle S+2+6r+k.
//    Word (r,k) on gpu_data during cycle S+4+6r+k (gpu READ_X..READ_COLOR slot).
//    Last word (63,4) at S+386; DONE at S+387: done=1, busy=0; IDLE from S+388.
//  - gpu_data = 0 in gap slots, IDLE and DONE; mem_rd_en = 0 outside read cycles, mem_addr holds.
//  - start while busy or in DONE: ignored, not queued. start held high: new copy begins S+388.
//  - width/height passed raw; gpu computes right/bottom itself.
// CONFIGURATION
//  RECT_COPY_SCROLL_EN defined: adds inputs scroll_x, scroll_y (DATA_WIDTH), latched at accepted
//   start; word k=0 sent as x+scroll_x, k=1 as y+scroll_y, mod 2^DATA_WIDTH; others unchanged.
//  Undefined: no scroll ports; all words passed through unmodified.
// STRUCTURE
//  gpu_pkg: RECT_WORDS=5, GPU_SLOTS_PER_RECT=6, rect word index enum (X,Y,W,H,COLOR),
//   copy FSM state typedef; shared with gpu.
//  Sub-module rect_copy_addr_gen: slot/rect counters + mem_addr/mem_rd_en generation;
//   top holds FSM, output register, scroll adder.
// TESTING
//  1 base_addr=0x0100, RAM[a]=a, start pulse -> gpu_reset at S+1, copy_start at S+2,
//    gpu_data=0x0100 at S+4, 0x0104 at S+8, 0 at S+9, 0x0105 at S+10, done at S+387.
//  2 Full frame into gpu model: 64 rects with distinct colors -> gpu rect arrays match RAM, gpu
//    state EXECUTE, pixel inside rect 63 returns rect 63 color.
//  3 start re-pulsed at S+100 and at S+387 -> ignored; exactly one done; busy continuous S+1..S+386.
//  4 reset at S+200 -> next cycle all outputs 0, IDLE; new start runs full sequence normally.
//  5 base_addr=0xFFF0 -> word (3,2) read from 0x0001 (wrap), no X/glitch.
//  6 RECT_COPY_SCROLL_EN, scroll_x=0xFFFF, scroll_y=2, RAM x=5,y=7 -> gpu sees x=4, y=9, w/h/color raw.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared rect-load definitions used by rect_copy_controller and the gpu block.
package gpu_pkg;

    localparam int RECT_WORDS         = 5;
    localparam int GPU_SLOTS_PER_RECT = 6;

    typedef enum logic [2:0] {
        WORD_X     = 3'd0,
        WORD_Y     = 3'd1,
        WORD_W     = 3'd2,
        WORD_H     = 3'd3,
        WORD_COLOR = 3'd4
    } rect_word_e;

    typedef enum logic [2:0] {
        COPY_IDLE,
        COPY_GPU_RST,
        COPY_START,
        COPY_STREAM,
        COPY_DONE
    } copy_state_e;

endpackage

// File: rtl/rect_copy_addr_gen.sv
// Slot/rect counters and RAM read strobe/address for the rect copy stream.
module rect_copy_addr_gen
    import gpu_pkg::*;
#(
    parameter int RECT_COUNT = 64,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  pixel_clk,
    input  logic                  reset,
    input  logic                  launch,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output rect_word_e            rd_word,
    output logic                  rd_last
);

    localparam int RECT_W = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;
    localparam logic [RECT_W-1:0] LAST_RECT = RECT_W'(RECT_COUNT - 1);
    localparam logic [2:0]        LAST_WORD = 3'(RECT_WORDS - 1);
    localparam logic [2:0]        LAST_SLOT = 3'(GPU_SLOTS_PER_RECT - 1);

    logic              active;
    logic [2:0]        slot_q;
    logic [RECT_W-1:0] rect_q;

    // Reads run two cycles ahead of gpu_data, so the read-side idle slot is the
    // last of each group of six; it lines up with the gpu gap slot of the next rect.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            active    <= 1'b0;
            slot_q    <= '0;
            rect_q    <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
        end else if (launch) begin
            active    <= 1'b1;
            slot_q    <= '0;
            rect_q    <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= base_addr;
        end else if (active) begin
            if (slot_q == LAST_SLOT) begin
                slot_q <= '0;
                if (rect_q == LAST_RECT) begin
                    active    <= 1'b0;
                    mem_rd_en <= 1'b0;
                end else begin
                    rect_q    <= rect_q + RECT_W'(1);
                    mem_rd_en <= 1'b1;
                    mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                end
            end else begin
                slot_q <= slot_q + 3'd1;
                if (slot_q == LAST_WORD) begin
                    mem_rd_en <= 1'b0;
                end else begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign rd_word = rect_word_e'(slot_q);
    assign rd_last = mem_rd_en && (rect_q == LAST_RECT) && (slot_q == LAST_WORD);

endmodule

// File: rtl/rect_copy_controller.sv
// Streams RECT_COUNT rect records from the rect RAM into the gpu with its 6-slot cadence.
// Optional scroll offsets on x/y are enabled by defining RECT_COPY_SCROLL_EN.
module rect_copy_controller
    import gpu_pkg::*;
#(
    parameter int RECT_COUNT = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  pixel_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  gpu_reset,
    output logic                  copy_start,
    output logic [DATA_WIDTH-1:0] gpu_data,
    output logic                  busy,
    output logic                  done
`ifdef RECT_COPY_SCROLL_EN
    ,
    input  logic [DATA_WIDTH-1:0] scroll_x,
    input  logic [DATA_WIDTH-1:0] scroll_y
`endif
);

    copy_state_e           state, next_state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] scroll_x_q, scroll_y_q;
    logic [DATA_WIDTH-1:0] word_adj;
    rect_word_e            rd_word, word_d1;
    logic                  rd_last, rd_d1, last_d1, gpu_last;
    logic                  accept;

    assign accept = (state == COPY_IDLE) && start;

    rect_copy_addr_gen #(
        .RECT_COUNT (RECT_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .launch    (state == COPY_GPU_RST),
        .base_addr (base_q),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .rd_word   (rd_word),
        .rd_last   (rd_last)
    );

`ifdef RECT_COPY_SCROLL_EN
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            scroll_x_q <= '0;
            scroll_y_q <= '0;
        end else if (accept) begin
            scroll_x_q <= scroll_x;
            scroll_y_q <= scroll_y;
        end
    end
`else
    assign scroll_x_q = '0;
    assign scroll_y_q = '0;
`endif

    always_comb begin
        word_adj = mem_dout;
        case (word_d1)
            WORD_X:  word_adj = mem_dout + scroll_x_q;
            WORD_Y:  word_adj = mem_dout + scroll_y_q;
            default: word_adj = mem_dout;
        endcase
    end

    // RAM data arrives one cycle after the read; gpu_data registers it one more cycle later.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state    <= COPY_IDLE;
            base_q   <= '0;
            rd_d1    <= 1'b0;
            word_d1  <= WORD_X;
            last_d1  <= 1'b0;
            gpu_last <= 1'b0;
            gpu_data <= '0;
        end else begin
            state    <= next_state;
            rd_d1    <= mem_rd_en;
            word_d1  <= rd_word;
            last_d1  <= rd_last;
            gpu_last <= rd_d1 && last_d1;
            gpu_data <= rd_d1 ? word_adj : '0;
            if (accept) begin
                base_q <= base_addr;
            end
        end
    end

    always_comb begin
        next_state = state;
        gpu_reset  = 1'b0;
        copy_start = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            COPY_IDLE: begin
                if (start) next_state = COPY_GPU_RST;
            end
            COPY_GPU_RST: begin
                gpu_reset  = 1'b1;
                busy       = 1'b1;
                next_state = COPY_START;
            end
            COPY_START: begin
                copy_start = 1'b1;
                busy       = 1'b1;
                next_state = COPY_STREAM;
            end
            COPY_STREAM: begin
                busy = 1'b1;
                if (gpu_last) next_state = COPY_DONE;
            end
            COPY_DONE: begin
                done       = 1'b1;
                next_state = COPY_IDLE;
            end
            default: next_state = COPY_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rect_copy_controller.sv
// Self-checking bench for rect_copy_controller against a cycle-offset reference model.
module tb_rect_copy_controller;

    localparam int RC      = 64;
    localparam int LAST_T  = 4 + 6 * (RC - 1) + 4;
    localparam int FRAME_T = LAST_T + 2;
    localparam int CAP_N   = 800;

    logic        pixel_clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_dout = 16'h0;
    logic        gpu_reset, copy_start, busy, done;
    logic [15:0] gpu_data;
`ifdef RECT_COPY_SCROLL_EN
    logic [15:0] sx = 16'h0;
    logic [15:0] sy = 16'h0;
`endif

    logic [15:0] ram [65536];
    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] cap_data [CAP_N];
    logic [15:0] cap_addr [CAP_N];
    logic        cap_rd   [CAP_N];
    logic        cap_done [CAP_N];
    logic        cap_busy [CAP_N];
    logic        cap_gr   [CAP_N];
    logic        cap_cs   [CAP_N];

    typedef struct packed {
        logic        gr, cs, busy, done, rd;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) if (mem_rd_en) mem_dout <= ram[mem_addr];

    rect_copy_controller dut (
        .pixel_clk  (pixel_clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .gpu_reset  (gpu_reset),
        .copy_start (copy_start),
        .gpu_data   (gpu_data),
        .busy       (busy),
        .done       (done)
`ifdef RECT_COPY_SCROLL_EN
        ,
        .scroll_x   (sx),
        .scroll_y   (sy)
`endif
    );

    // Expected outputs t cycles after the cycle in which start was accepted.
    function automatic exp_t model(input int t, input logic [15:0] base);
        exp_t e;
        int u, r, k;
        e      = '0;
        e.gr   = (t == 1);
        e.cs   = (t == 2);
        e.busy = (t >= 1) && (t <= LAST_T);
        e.done = (t == LAST_T + 1);
        if (t >= 2) begin
            u = t - 2; r = u / 6; k = u % 6;
            if (r < RC && k < 5) begin
                e.rd   = 1'b1;
                e.addr = 16'(int'(base) + 5 * r + k);
            end
        end
        if (t >= 4) begin
            u = t - 4; r = u / 6; k = u % 6;
            if (r < RC && k < 5) begin
                e.data = ram[16'(int'(base) + 5 * r + k)];
`ifdef RECT_COPY_SCROLL_EN
                if (k == 0) e.data = e.data + sx;
                if (k == 1) e.data = e.data + sy;
`endif
            end
        end
        return e;
    endfunction

    task automatic fill_random();
        for (int a = 0; a < 65536; a++) ram[a] = 16'($urandom);
    endtask

    task automatic run_copy(input logic [15:0] base, input bit repulse, input bit hold);
        int   nt, tt;
        exp_t e;
        nt = hold ? 2 * FRAME_T + 4 : FRAME_T + 4;
        @(posedge pixel_clk); #1;
        base_addr = base;
        start     = 1'b1;
        for (int t = 0; t < nt; t++) begin
            @(negedge pixel_clk);
            tt = (hold && t >= FRAME_T) ? t - FRAME_T : t;
            e  = model(tt, base);
            cap_data[t] = gpu_data; cap_addr[t] = mem_addr; cap_rd[t] = mem_rd_en;
            cap_done[t] = done; cap_busy[t] = busy; cap_gr[t] = gpu_reset; cap_cs[t] = copy_start;
            n_tests++;
            if ({gpu_reset, copy_start, busy, done, mem_rd_en} !== {e.gr, e.cs, e.busy, e.done, e.rd}) begin
                n_fail++;
                $display("FAIL ctrl t=%0d got rst/cs/busy/done/rd=%b expected %b", t,
                         {gpu_reset, copy_start, busy, done, mem_rd_en}, {e.gr, e.cs, e.busy, e.done, e.rd});
            end
            n_tests++;
            if (gpu_data !== e.data) begin
                n_fail++;
                $display("FAIL gpu_data t=%0d got %h expected %h", t, gpu_data, e.data);
            end
            if (e.rd) begin
                n_tests++;
                if (mem_addr !== e.addr) begin
                    n_fail++;
                    $display("FAIL mem_addr t=%0d got %h expected %h", t, mem_addr, e.addr);
                end
            end
            @(posedge pixel_clk); #1;
            start     = (hold && t + 1 <= FRAME_T) || (repulse && (t + 1 == 100 || t + 1 == LAST_T + 1));
            base_addr = (hold && t + 1 == FRAME_T) ? base : 16'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = 16'h0;
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        n_tests++;
        if ({gpu_reset, copy_start, busy, done, mem_rd_en, mem_addr, gpu_data} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_state got %b/%b/%b/%b/%b addr %h data %h expected all 0",
                     gpu_reset, copy_start, busy, done, mem_rd_en, mem_addr, gpu_data);
        end
        @(posedge pixel_clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        for (int a = 0; a < 65536; a++) ram[a] = 16'(a);
        run_copy(16'h0100, 1'b0, 1'b0);
        n_tests++;
        if ({cap_gr[1], cap_cs[2], cap_done[LAST_T + 1]} !== 3'b111) begin
            n_fail++;
            $display("FAIL directed_pulses got gr1/cs2/done387=%b expected 111",
                     {cap_gr[1], cap_cs[2], cap_done[LAST_T + 1]});
        end
        n_tests++;
        if ({cap_data[4], cap_data[8], cap_data[9], cap_data[10]} !== {16'h0100, 16'h0104, 16'h0000, 16'h0105}) begin
            n_fail++;
            $display("FAIL directed_data got %h %h %h %h expected 0100 0104 0000 0105",
                     cap_data[4], cap_data[8], cap_data[9], cap_data[10]);
        end
    endtask

    task automatic test_full_frame();
        logic [15:0] base;
        logic [79:0] got, want;
        base = 16'($urandom);
        fill_random();
        for (int r = 0; r < RC; r++) ram[16'(int'(base) + 5 * r + 4)] = 16'(r * 257 + 3);
        run_copy(base, 1'b0, 1'b0);
        for (int r = 0; r < RC; r++) begin
            for (int k = 0; k < 5; k++) begin
                got[79 - 16 * k -: 16]  = cap_data[4 + 6 * r + k];
                want[79 - 16 * k -: 16] = ram[16'(int'(base) + 5 * r + k)];
            end
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL frame_rect%0d got %h expected %h", r, got, want);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int  dones;
        bit  busy_ok;
        fill_random();
        run_copy(16'($urandom), 1'b1, 1'b0);
        dones = 0; busy_ok = 1'b1;
        for (int t = 0; t < FRAME_T + 4; t++) begin
            if (cap_done[t]) dones++;
            if (cap_busy[t] !== ((t >= 1) && (t <= LAST_T))) busy_ok = 1'b0;
        end
        n_tests++;
        if (dones != 1 || !busy_ok) begin
            n_fail++;
            $display("FAIL restart_ignored got dones=%0d busy_ok=%0d expected 1 and 1", dones, busy_ok);
        end
    endtask

    task automatic test_mid_reset();
        fill_random();
        @(posedge pixel_clk); #1;
        base_addr = 16'($urandom); start = 1'b1;
        @(posedge pixel_clk); #1;
        start = 1'b0;
        repeat (199) @(posedge pixel_clk);
        #1 reset = 1'b1;
        @(negedge pixel_clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre busy got %b expected 1", busy);
        end
        @(posedge pixel_clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pixel_clk);
            n_tests++;
            if ({gpu_reset, copy_start, busy, done, mem_rd_en, mem_addr, gpu_data} !== 37'h0) begin
                n_fail++;
                $display("FAIL midreset_idle c%0d got %b/%b/%b/%b/%b addr %h data %h expected all 0", i,
                         gpu_reset, copy_start, busy, done, mem_rd_en, mem_addr, gpu_data);
            end
        end
        run_copy(16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        fill_random();
        run_copy(16'hFFF0, 1'b0, 1'b0);
        n_tests++;
        if ({cap_rd[22], cap_addr[22]} !== {1'b1, 16'h0001}) begin
            n_fail++;
            $display("FAIL wrap_addr got rd=%b addr=%h expected rd=1 addr=0001", cap_rd[22], cap_addr[22]);
        end
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_copy(16'($urandom), 1'b0, 1'b1);
        n_tests++;
        if ({cap_gr[FRAME_T + 1], cap_done[2 * FRAME_T - 1]} !== 2'b11) begin
            n_fail++;
            $display("FAIL back_to_back got gr=%b done=%b expected 11",
                     cap_gr[FRAME_T + 1], cap_done[2 * FRAME_T - 1]);
        end
    endtask

`ifdef RECT_COPY_SCROLL_EN
    task automatic test_scroll();
        logic [15:0] base;
        base = 16'h2000;
        fill_random();
        ram[base] = 16'd5; ram[base + 16'd1] = 16'd7;
        sx = 16'hFFFF; sy = 16'h0002;
        run_copy(base, 1'b0, 1'b0);
        n_tests++;
        if ({cap_data[4], cap_data[5], cap_data[6], cap_data[8]} !==
            {16'd4, 16'd9, ram[base + 16'd2], ram[base + 16'd4]}) begin
            n_fail++;
            $display("FAIL scroll got %h %h %h %h expected 0004 0009 %h %h", cap_data[4], cap_data[5],
                     cap_data[6], cap_data[8], ram[base + 16'd2], ram[base + 16'd4]);
        end
        sx = 16'h0; sy = 16'h0;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_full_frame();
        test_restart_ignored();
        test_mid_reset();
        test_wrap();
        test_back_to_back();
`ifdef RECT_COPY_SCROLL_EN
        test_scroll();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
